// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: ALU operation codes and
// the bus-source priority order (highest priority first).
package datapath_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_SHR = 4'b0100,
        ALU_SHL = 4'b0101,
        ALU_ROR = 4'b0110,
        ALU_ROL = 4'b0111,
        ALU_MUL = 4'b1000,
        ALU_DIV = 4'b1001,
        ALU_NEG = 4'b1010,
        ALU_NOT = 4'b1011
    } alu_op_e;

    // Enumeration order is the bus arbitration order.
    typedef enum logic [3:0] {
        SRC_GPR,
        SRC_HI,
        SRC_LO,
        SRC_ZHI,
        SRC_ZLO,
        SRC_PC,
        SRC_MDR,
        SRC_INPORT,
        SRC_CONST,
        SRC_NONE
    } bus_src_e;

    localparam int CONST_W = 19;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A (from Y) and B (from the bus) produce a 64-bit result
// destined for Z. inc_pc overrides the opcode with B+1.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [3:0]          alu_op,
    input  logic                inc_pc,
    output logic [2*DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    logic signed [DATA_W-1:0]   a_s;
    logic signed [DATA_W-1:0]   b_s;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [SH_W-1:0]            sh;
    logic [2*DATA_W-1:0]        dbl;
    logic [2*DATA_W-1:0]        ror_full;
    logic [2*DATA_W-1:0]        rol_full;
    logic                       div_ovf;

    assign a_s      = a;
    assign b_s      = b;
    assign a_ext    = a_s;
    assign b_ext    = b_s;
    assign prod     = a_ext * b_ext;
    assign sh       = b[SH_W-1:0];
    // Rotates fall out of shifting a doubled copy of A.
    assign dbl      = {a, a};
    assign ror_full = dbl >> sh;
    assign rol_full = dbl << sh;
    // Most-negative / -1 does not fit; pin it to the wrapped quotient.
    assign div_ovf  = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == {DATA_W{1'b1}});

    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[DATA_W-1:0] = b + DATA_W'(1);
        end else begin
            case (alu_op)
                ALU_AND: result[DATA_W-1:0] = a & b;
                ALU_OR:  result[DATA_W-1:0] = a | b;
                ALU_ADD: result[DATA_W-1:0] = a + b;
                ALU_SUB: result[DATA_W-1:0] = a - b;
                ALU_SHR: result[DATA_W-1:0] = a >> sh;
                ALU_SHL: result[DATA_W-1:0] = a << sh;
                ALU_ROR: result[DATA_W-1:0] = ror_full[DATA_W-1:0];
                ALU_ROL: result[DATA_W-1:0] = rol_full[2*DATA_W-1:DATA_W];
                ALU_MUL: result = prod;
                ALU_DIV: begin
                    if (b == '0) begin
                        result = {a, {DATA_W{1'b1}}};
                    end else if (div_ovf) begin
                        result = {{DATA_W{1'b0}}, a};
                    end else begin
                        result = {DATA_W'(a_s % b_s), DATA_W'(a_s / b_s)};
                    end
                end
                ALU_NEG: result[DATA_W-1:0] = -b;
                ALU_NOT: result[DATA_W-1:0] = ~b;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU.
// Optional INPORT_EN adds the inport_data port and the sampled INPORT register.
module datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_GPR = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_GPR-1:0] gpr_in,
    input  logic [NUM_GPR-1:0] gpr_out,
    input  logic               hi_in,
    input  logic               lo_in,
    input  logic               hi_out,
    input  logic               lo_out,
    input  logic               pc_in,
    input  logic               pc_out,
    input  logic               ir_in,
    input  logic               z_in,
    input  logic               z_high_out,
    input  logic               z_low_out,
    input  logic               inport_out,
    input  logic               c_out,
    input  logic               y_in,
    input  logic               mar_in,
    input  logic               mdr_in,
    input  logic               mdr_out,
    input  logic               read,
    input  logic [DATA_W-1:0]  m_data_in,
    input  logic [3:0]         alu_op,
    input  logic               inc_pc,
`ifdef INPORT_EN
    input  logic [DATA_W-1:0]  inport_data,
`endif
    output logic [DATA_W-1:0]  bus_data
);

    localparam int GPR_IDX_W = $clog2(NUM_GPR);

    logic [DATA_W-1:0]   gpr [NUM_GPR];
    logic [DATA_W-1:0]   hi, lo, pc, ir, y, mar, mdr;
    logic [2*DATA_W-1:0] z;
    logic [2*DATA_W-1:0] alu_res;
    logic [DATA_W-1:0]   inport_val;
    logic [DATA_W-1:0]   const_val;
    logic [GPR_IDX_W-1:0] gpr_sel;
    bus_src_e            src;

`ifdef INPORT_EN
    logic [DATA_W-1:0] inport_q;

    always_ff @(posedge clk) begin
        if (!reset_n) inport_q <= '0;
        else          inport_q <= inport_data;
    end

    assign inport_val = inport_q;
`else
    assign inport_val = '0;
`endif

    assign const_val = {{(DATA_W-CONST_W){ir[CONST_W-1]}}, ir[CONST_W-1:0]};

    // Bus arbitration: lowest-index GPR first, then the fixed special-register order.
    always_comb begin
        gpr_sel = '0;
        for (int i = NUM_GPR-1; i >= 0; i--) begin
            if (gpr_out[i]) gpr_sel = GPR_IDX_W'(i);
        end
        if      (|gpr_out)   src = SRC_GPR;
        else if (hi_out)     src = SRC_HI;
        else if (lo_out)     src = SRC_LO;
        else if (z_high_out) src = SRC_ZHI;
        else if (z_low_out)  src = SRC_ZLO;
        else if (pc_out)     src = SRC_PC;
        else if (mdr_out)    src = SRC_MDR;
        else if (inport_out) src = SRC_INPORT;
        else if (c_out)      src = SRC_CONST;
        else                 src = SRC_NONE;
    end

    always_comb begin
        case (src)
            SRC_GPR:    bus_data = gpr[gpr_sel];
            SRC_HI:     bus_data = hi;
            SRC_LO:     bus_data = lo;
            SRC_ZHI:    bus_data = z[2*DATA_W-1:DATA_W];
            SRC_ZLO:    bus_data = z[DATA_W-1:0];
            SRC_PC:     bus_data = pc;
            SRC_MDR:    bus_data = mdr;
            SRC_INPORT: bus_data = inport_val;
            SRC_CONST:  bus_data = const_val;
            default:    bus_data = '0;
        endcase
    end

    datapath_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (y),
        .b      (bus_data),
        .alu_op (alu_op),
        .inc_pc (inc_pc),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            hi  <= '0;
            lo  <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            mar <= '0;
            mdr <= '0;
            z   <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gpr_in[i]) gpr[i] <= bus_data;
            end
            if (hi_in)  hi  <= bus_data;
            if (lo_in)  lo  <= bus_data;
            if (pc_in)  pc  <= bus_data;
            if (ir_in)  ir  <= bus_data;
            if (y_in)   y   <= bus_data;
            if (mar_in) mar <= bus_data;
            if (mdr_in) mdr <= read ? m_data_in : bus_data;
            if (z_in)   z   <= alu_res;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed sequences, an ALU vector table and
// randomized ALU operations checked against a behavioural model.
module tb_datapath;
    import datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] gpr_in, gpr_out;
    logic        hi_in, lo_in, hi_out, lo_out, pc_in, pc_out, ir_in, z_in;
    logic        z_high_out, z_low_out, inport_out, c_out, y_in, mar_in;
    logic        mdr_in, mdr_out, read, inc_pc;
    logic [31:0] m_data_in;
    logic [3:0]  alu_op;
    logic [31:0] bus_data;
`ifdef INPORT_EN
    logic [31:0] inport_data = 32'h0;
`endif

    always #5 clk = ~clk;

    datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpr_in     (gpr_in),
        .gpr_out    (gpr_out),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .pc_in      (pc_in),
        .pc_out     (pc_out),
        .ir_in      (ir_in),
        .z_in       (z_in),
        .z_high_out (z_high_out),
        .z_low_out  (z_low_out),
        .inport_out (inport_out),
        .c_out      (c_out),
        .y_in       (y_in),
        .mar_in     (mar_in),
        .mdr_in     (mdr_in),
        .mdr_out    (mdr_out),
        .read       (read),
        .m_data_in  (m_data_in),
        .alu_op     (alu_op),
        .inc_pc     (inc_pc),
`ifdef INPORT_EN
        .inport_data(inport_data),
`endif
        .bus_data   (bus_data)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          inc;
        logic [63:0] exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        gpr_in = '0; gpr_out = '0;
        hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; pc_in = 0; pc_out = 0;
        ir_in = 0; z_in = 0; z_high_out = 0; z_low_out = 0; inport_out = 0;
        c_out = 0; y_in = 0; mar_in = 0; mdr_in = 0; mdr_out = 0; read = 0;
        inc_pc = 0; alu_op = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clr(); read = 1; mdr_in = 1; m_data_in = v; step(); clr();
    endtask

    task automatic to_gpr(input int i, input logic [31:0] v);
        load_mdr(v); mdr_out = 1; gpr_in[i] = 1'b1; step(); clr();
    endtask

    task automatic alu_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit inc, output logic [63:0] zv);
        load_mdr(a); mdr_out = 1; y_in = 1; step(); clr();
        load_mdr(b); mdr_out = 1; alu_op = op; inc_pc = inc; z_in = 1; step(); clr();
        z_low_out = 1;  #1 zv[31:0]  = bus_data; clr();
        z_high_out = 1; #1 zv[63:32] = bus_data; clr();
    endtask

    // Reference ALU built from the operation definitions with wide integer arithmetic.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit inc);
        longint sa, sb, q, rm, p;
        logic [31:0] r;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        if (inc) return {32'h0, b + 32'h1};
        case (op)
            4'd0:  return {32'h0, a & b};
            4'd1:  return {32'h0, a | b};
            4'd2:  return {32'h0, a + b};
            4'd3:  return {32'h0, a - b};
            4'd4:  return {32'h0, a >> sh};
            4'd5:  return {32'h0, a << sh};
            4'd6: begin
                r = a;
                for (int k = 0; k < sh; k++) r = {r[0], r[31:1]};
                return {32'h0, r};
            end
            4'd7: begin
                r = a;
                for (int k = 0; k < sh; k++) r = {r[30:0], r[31]};
                return {32'h0, r};
            end
            4'd8: begin
                p = sa * sb;
                return p;
            end
            4'd9: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            4'd10: return {32'h0, 32'h0 - b};
            4'd11: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    vec_t        vecs[$];
    logic [63:0] zv;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    bit          rinc;

    initial begin
        clr();
        m_data_in = '0;
        reset_n = 0;
        step(); step();
        reset_n = 1;

        // Fill every register with non-zero data, then reset for one edge.
        for (int i = 0; i < 16; i++) to_gpr(i, 32'h1111_1111 * (i + 1));
        load_mdr(32'hAAAA_0001); mdr_out = 1; hi_in = 1; lo_in = 1; pc_in = 1; ir_in = 1; y_in = 1; step(); clr();
        load_mdr(32'h5); mdr_out = 1; alu_op = ALU_MUL; z_in = 1; step(); clr();
        reset_n = 0; step(); reset_n = 1;

        for (int i = 0; i < 16; i++) begin
            gpr_out[i] = 1'b1; #1 check($sformatf("reset_r%0d", i), bus_data, 32'h0); clr();
        end
        hi_out = 1;     #1 check("reset_hi", bus_data, 32'h0);  clr();
        lo_out = 1;     #1 check("reset_lo", bus_data, 32'h0);  clr();
        z_high_out = 1; #1 check("reset_zhi", bus_data, 32'h0); clr();
        z_low_out = 1;  #1 check("reset_zlo", bus_data, 32'h0); clr();
        pc_out = 1;     #1 check("reset_pc", bus_data, 32'h0);  clr();
        mdr_out = 1;    #1 check("reset_mdr", bus_data, 32'h0); clr();
        c_out = 1;      #1 check("reset_ir", bus_data, 32'h0);  clr();
        #1 check("bus_idle", bus_data, 32'h0);

        // Register loads through MDR.
        to_gpr(2, 32'h22); to_gpr(4, 32'h24); to_gpr(5, 32'h26);
        gpr_out[2] = 1; #1 check("r2", bus_data, 32'h22); clr();
        gpr_out[4] = 1; #1 check("r4", bus_data, 32'h24); clr();
        gpr_out[5] = 1; #1 check("r5", bus_data, 32'h26); clr();

        // Fetch-style sequence followed by R5 = R2 + R4.
        pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1; step(); clr();
        z_low_out = 1; pc_in = 1; #1 check("z_pc_inc", bus_data, 32'h1); step(); clr();
        pc_out = 1; #1 check("pc_after_inc", bus_data, 32'h1); clr();
        load_mdr(32'h1A92_0000); mdr_out = 1; ir_in = 1; step(); clr();
        c_out = 1; #1 check("ir_const", bus_data, 32'h0002_0000); clr();
        gpr_out[2] = 1; y_in = 1; step(); clr();
        gpr_out[4] = 1; alu_op = ALU_ADD; z_in = 1; step(); clr();
        z_low_out = 1; gpr_in[5] = 1; #1 check("add_bus", bus_data, 32'h46); step(); clr();
        gpr_out[5] = 1; #1 check("add_r5", bus_data, 32'h46); clr();

        // Simultaneous load and drive keeps the old value; overlapping drives resolve by priority.
        gpr_out[4] = 1; gpr_in[4] = 1; step(); clr();
        gpr_out[4] = 1; #1 check("self_load", bus_data, 32'h24); clr();
        gpr_out[5] = 1; gpr_out[2] = 1; #1 check("prio_gpr", bus_data, 32'h22); clr();
        load_mdr(32'h7777_0000); mdr_out = 1; hi_in = 1; step(); clr();
        hi_out = 1; #1 check("hi_load", bus_data, 32'h7777_0000); clr();
        hi_out = 1; gpr_out[15] = 1; #1 check("prio_gpr_hi", bus_data, 32'h0); clr();
        hi_out = 1; pc_out = 1; mdr_out = 1; #1 check("prio_hi_pc", bus_data, 32'h7777_0000); clr();
        load_mdr(32'h0BAD_0000); mdr_out = 1; lo_in = 1; step(); clr();
        lo_out = 1; #1 check("lo_load", bus_data, 32'h0BAD_0000); clr();

        // MDR taking its value from the bus when read is low.
        gpr_out[4] = 1; mdr_in = 1; step(); clr();
        mdr_out = 1; #1 check("mdr_from_bus", bus_data, 32'h24); clr();

        // Constant sign extension and input port.
        load_mdr(32'h0007_FFFF); mdr_out = 1; ir_in = 1; step(); clr();
        c_out = 1; #1 check("c_neg", bus_data, 32'hFFFF_FFFF); clr();
        load_mdr(32'hFFF3_FFFF); mdr_out = 1; ir_in = 1; step(); clr();
        c_out = 1; #1 check("c_pos", bus_data, 32'h0003_FFFF); clr();
`ifdef INPORT_EN
        inport_data = 32'h1234; step();
        inport_out = 1; #1 check("inport", bus_data, 32'h1234); clr();
`else
        inport_out = 1; #1 check("inport_off", bus_data, 32'h0); clr();
`endif

        // ALU vector table.
        vecs.push_back('{ALU_MUL, 32'hFFFF_FFFE, 32'h3, 0, 64'hFFFF_FFFF_FFFF_FFFA});
        vecs.push_back('{ALU_DIV, 32'h7, 32'h2, 0, 64'h0000_0001_0000_0003});
        vecs.push_back('{ALU_DIV, 32'h7, 32'h0, 0, 64'h0000_0007_FFFF_FFFF});
        vecs.push_back('{ALU_DIV, 32'hFFFF_FFF9, 32'h2, 0, 64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{ALU_SHR, 32'h8000_0001, 32'h1, 0, 64'h4000_0000});
        vecs.push_back('{ALU_SHL, 32'h8000_0001, 32'h1, 0, 64'h0000_0002});
        vecs.push_back('{ALU_ROR, 32'h8000_0001, 32'h1, 0, 64'hC000_0000});
        vecs.push_back('{ALU_ROL, 32'h8000_0001, 32'h1, 0, 64'h0000_0003});
        vecs.push_back('{ALU_NEG, 32'h8000_0001, 32'h5, 0, 64'hFFFF_FFFB});
        vecs.push_back('{ALU_NOT, 32'h8000_0001, 32'h5, 0, 64'hFFFF_FFFA});
        vecs.push_back('{ALU_ADD, 32'hFFFF_FFFF, 32'h2, 0, 64'h0000_0001});
        vecs.push_back('{ALU_SUB, 32'h0, 32'h1, 0, 64'hFFFF_FFFF});
        vecs.push_back('{ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 64'hF000_F000});
        vecs.push_back('{ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 0, 64'hFFF0_FFF0});
        vecs.push_back('{4'b1100, 32'h1234_5678, 32'h9, 0, 64'h0});
        vecs.push_back('{ALU_MUL, 32'h5, 32'hFFFF_FFFF, 1, 64'h0});
        foreach (vecs[i]) begin
            alu_run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inc, zv);
            check($sformatf("vec%0d_zlo", i), zv[31:0],  vecs[i].exp[31:0]);
            check($sformatf("vec%0d_zhi", i), zv[63:32], vecs[i].exp[63:32]);
        end

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            rop  = 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rinc = ($urandom_range(0, 7) == 0);
            alu_run(rop, ra, rb, rinc, zv);
            check($sformatf("rnd%0d_op%0d_zlo", n, rop), zv[31:0],  ref_alu(rop, ra, rb, rinc) >> 0);
            check($sformatf("rnd%0d_op%0d_zhi", n, rop), zv[63:32], ref_alu(rop, ra, rb, rinc) >> 32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath: 16 GPRs, HI, LO, PC, IR, Y, 64-bit Z, MAR, MDR and a combinational ALU, all sharing one 32-bit bus.
- Driven by one-hot load/drive strobes from an external control unit.
- Exports the live bus value for observation.

Parameters:
- DATA_W, 32, bus/register width (fixed at 32; all widths below assume it).
- NUM_GPR, 16, number of general-purpose registers.

Ports:
- clk  in  1  system clock, all registers update on rising edge
- reset_n  in  1  synchronous active-low reset
- gpr_in  in  16  bit i loads R[i] from bus
- gpr_out  in  16  bit i drives R[i] onto bus
- hi_in, lo_in  in  1 each  load HI/LO from bus
- hi_out, lo_out  in  1 each  drive HI/LO onto bus
- pc_in / pc_out  in  1 each  load/drive PC
- ir_in  in  1  load IR from bus
- z_in  in  1  load 64-bit Z from ALU result
- z_high_out / z_low_out  in  1 each  drive Z[63:32] / Z[31:0]
- inport_out  in  1  drive input-port value
- c_out  in  1  drive sign-extended IR[18:0] constant
- y_in  in  1  load Y from bus
- mar_in  in  1  load MAR from bus
- mdr_in  in  1  load MDR
- mdr_out  in  1  drive MDR
- read  in  1  MDR source select: 1 = m_data_in, 0 = bus
- m_data_in  in  32  memory read data
- alu_op  in  4  ALU operation
- inc_pc  in  1  force ALU result = bus + 1
- bus_data  out  32  current bus value

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low. At a rising edge with reset_n=0, all registers clear to 0, and the Z, MAR and MDR registers clear as well. Otherwise each register loads when its strobe is 1.
- Bus: combinational priority mux, first match wins: gpr_out (lowest index first), hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out, inport_out, c_out. No driver selected -> 0. Control issues one-hot drives; the priority only defines illegal overlap.
- MDR: loads m_data_in when read=1, else bus.
- ALU operands and result: A=Y, B=bus. Result is 64-bit and is written to Z on z_in.
- And 0000: A&B.
- Or 0001: A|B.
- Add 0010: A+B.
- Sub 0011: A-B.
- Shr 0100: logical A>>B[4:0].
- Shl 0101: A<<B[4:0].
- Ror 0110: rotate right by B[4:0].
- Rol 0111: rotate left by B[4:0].
- Mul 1000: signed 32x32 -> 64-bit product, full width into Z.
- Div 1001: signed. Zlo = quotient, truncated toward zero; Zhi = remainder, sign of dividend. B=0: Zlo=FFFFFFFF, Zhi=A.
- Neg 1010: -B.
- Not 1011: ~B.
- Codes 1100-1111 yield 0.
- For all non-Mul/Div ops, Zhi = 0.
- inc_pc=1 overrides alu_op: result = {32'b0, B+1}.
- Add/Sub wrap modulo 2^32; there is no carry/overflow flag.
- c_out value: {{13{IR[18]}}, IR[18:0]}.
- Latency: bus/ALU purely combinational. A register loaded at edge k is drivable in the cycle after edge k.
- Simultaneous load and drive of the same register: the bus carries the old value, and the register captures it (no-op).

Optional Feature:
- Macro: INPORT_EN.
- Defined: adds input port inport_data[31:0] and a 32-bit INPORT register. The register samples inport_data every clock and resets to 0. inport_out drives INPORT onto the bus.
- Undefined: no inport_data port; inport_out drives 0 onto the bus.

Decomposition:
- Shared package: alu_op encodings (And..Not constants) and the bus-source priority order.
- Natural sub-module: alu (A, B, alu_op, inc_pc -> 64-bit result). Registers and bus mux stay in datapath.

Test Plan:
- Reset: reset_n=0 for one edge. Every register reads 0 via its drive strobe; bus_data=0 with no driver.
- Register load: read=1, mdr_in with m_data_in=22; then mdr_out+gpr_in[2]. Repeat with 24->R4 and 26->R5; each readback shows the value.
- Add sequence:
  - pc_out+mar_in+inc_pc+z_in -> Z=1.
  - z_low_out+pc_in -> PC=1.
  - read+mdr_in with 1A920000, then mdr_out+ir_in -> IR=1A920000.
  - r2_out+y_in; then r4_out+alu_op=Add+z_in; then z_low_out+gpr_in[5] -> R5=46, bus_data=46.
- Mul/Div: Y=FFFFFFFE (-2), B=3, Mul -> Zhi=FFFFFFFF, Zlo=FFFFFFFA. Y=7, B=2, Div -> Zlo=3, Zhi=1. B=0 -> Zlo=FFFFFFFF, Zhi=7.
- Shift/rotate/unary: Y=80000001, B=1. Shr -> 40000000; Shl -> 00000002; Ror -> C0000000; Rol -> 00000003. B=5: Neg -> FFFFFFFB, Not -> FFFFFFFA.
- Constant/inport: IR=0007FFFF, c_out -> bus FFFFFFFF. With INPORT_EN, inport_data=1234 -> bus 1234 next cycle; without it -> 0.
